log_unpacked_to_compact_pipe: RTL and testbench
===============================================

Name: log_unpacked_to_compact_pipe

Overview:
- Multi-lane, pipelined converter from unpacked log numbers (sign, isZero, isInf, signed log exponent, log fraction) to compact posit-encoded log words.
- Generalises the single-lane combinational unpacked-to-compact conversion with LANES parallel lanes, a valid/ready elastic 2-stage pipeline, and selectable rounding mode and underflow policy.
- Adds saturating underflow/overflow event counters.
- Sits at the output of log-domain accumulators and feeds packed results to memory/interconnect.

Parameters:
- WIDTH, 8, compact word width per lane.
- LS, 1, log scale (posit ES equivalent).
- LANES, 4, number of independent lanes.
- UNDERFLOW_SAT, 0, 0 = flush underflow to zero; 1 = saturate underflow to minpos (same sign).
- CNT_W, 16, event counter width.
- Derived, not overridable: M = PositDef::getSignedExponentBits(WIDTH, LS); F = PositDef::getFractionBits(WIDTH, LS).

Ports:
- clock  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inValid  in  1  input beat valid.
- inReady  out  1  block accepts a beat this cycle.
- inSign  in  LANES  per-lane sign.
- inIsZero  in  LANES  per-lane zero flag.
- inIsInf  in  LANES  per-lane inf flag.
- inSignedLogExp  in  LANES*M  per-lane signed exponent; lane i at [i*M +: M].
- inLogFrac  in  LANES*F  per-lane fraction.
- inTrailingBits  in  LANES*2  per-lane guard/round bits.
- inStickyBit  in  LANES  per-lane sticky bit.
- inRoundMode  in  1  0 = round-to-nearest-even, 1 = truncate; sampled with the beat.
- outValid  out  1  output beat valid.
- outReady  in  1  downstream accepts.
- outBits  out  LANES*WIDTH  packed compact words; lane i at [i*WIDTH +: WIDTH].
- clearCounts  in  1  synchronous counter clear.
- underflowCount  out  CNT_W  lanes that underflowed since clear.
- overflowCount  out  CNT_W  lanes that overflowed since clear.

Behaviour:
- Reset (resetn low, asynchronous):
  - both stage valids = 0, so outValid = 0 and inReady = 1;
  - outBits = 0;
  - both counters = 0.
- Handshake:
  - adv = !outValid || outReady; inReady = adv.
  - A beat is accepted when inValid && inReady.
  - Stage 1 captures pre-round lane data; stage 2 holds encoded bits.
  - Both stages advance together when adv is high.
  - Latency is exactly 2 cycles from acceptance to outValid when outReady is held high.
  - Throughput is 1 beat/cycle.
  - While outValid && !outReady: outBits and outValid hold stable, and no beat is accepted.
- Stage 1, per lane:
  - underflow = !isZero && !isInf && signedLogExp < getMinSignedExponent.
  - overflow = !isZero && !isInf && signedLogExp > max representable exponent.
  - Zero/inf pass through with exponent = 0 and fraction = 0.
  - Underflow, UNDERFLOW_SAT = 0: isZero = 1.
  - Underflow, UNDERFLOW_SAT = 1: produce minpos with the input sign; the rounding bits are ignored.
  - Otherwise: unsigned exponent = signedLogExp + getExponentBias, fraction = logFrac.
  - Trailing, sticky and round mode are registered alongside the lane data.
- Stage 2, per lane:
  - RNE mode: PositRoundToNearestEven followed by PositEncode.
  - Truncate mode: trailing and sticky are forced to 0 before the rounder.
  - Overflow saturates to maxpos, never inf.
  - Rounding up from maxpos stays at maxpos.
- Counters:
  - On acceptance, each counter increments by the popcount of that beat's per-lane underflow (resp. overflow) flags.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - When clearCounts is high, the counter becomes 0 that cycle and the increment from the same cycle is discarded.
- Zero and inf inputs never count.
- Lanes are fully independent; a mix of flags across lanes is legal.
- Reset mid-operation drops in-flight beats; no partial output is produced.

Test Plan (WIDTH=8, LS=1, LANES=4):
- Exponent 0, fraction 0, trailing 2'b00, RNE, outReady=1 → outBits lane = 8'h40 exactly 2 cycles after acceptance. Then trailing 2'b10, sticky 0 → 8'h40 (tie to even); trailing 2'b10, sticky 1 → 8'h41; trailing 2'b11 in truncate mode → 8'h40.
- Lane exponents {-13, 13, 0, -12}, fraction 0, UNDERFLOW_SAT=0 → lanes {8'h00, 8'h7F, 8'h40, 8'h01}; underflowCount = 1, overflowCount = 1. Repeat with UNDERFLOW_SAT=1 and negative sign on lane 0 → lane 0 = 8'hFF (negative minpos).
- isInf on lane 1, isZero on lane 2, each with an exponent out of range → 8'h80 and 8'h00; counters unchanged.
- Stream 6 consecutive beats with outReady toggling 1,0,0,1,1,1 → every beat is delivered once and in order; outBits is stable while stalled; inReady = 0 during stall cycles.
- With the underflow counter preset near max (CNT_W=4 build), 16 underflowing lanes plus more → counter holds at 15. Asserting clearCounts on a cycle with 2 underflowing lanes accepted → counter reads 0 the next cycle.
- Assert resetn low with 2 beats in flight → outValid = 0 immediately (asynchronously); after release, no stale beat appears and counters = 0.

Source files
------------

// File: rtl/log_unpacked_to_compact_pipe.sv
// Multi-lane, two-stage elastic converter from unpacked log numbers to compact posit-style log words.
// Stage 1 classifies and biases each lane's exponent; stage 2 rounds and encodes.
module log_unpacked_to_compact_pipe #(
   parameter int WIDTH         = 8,
   parameter int LS            = 1,
   parameter int LANES         = 4,
   parameter int UNDERFLOW_SAT = 0,
   parameter int CNT_W         = 16,
   localparam int MAX_EXP      = (WIDTH - 2) << LS,
   localparam int M            = $clog2(MAX_EXP + 1) + 1,
   localparam int F            = WIDTH - 3 - LS
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     inValid,
   output logic                     inReady,
   input  logic [LANES-1:0]         inSign,
   input  logic [LANES-1:0]         inIsZero,
   input  logic [LANES-1:0]         inIsInf,
   input  logic [LANES*M-1:0]       inSignedLogExp,
   input  logic [LANES*F-1:0]       inLogFrac,
   input  logic [LANES*2-1:0]       inTrailingBits,
   input  logic [LANES-1:0]         inStickyBit,
   input  logic                     inRoundMode,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [LANES*WIDTH-1:0]   outBits,
   input  logic                     clearCounts,
   output logic [CNT_W-1:0]         underflowCount,
   output logic [CNT_W-1:0]         overflowCount
);

   localparam int          MIN_EXP = -MAX_EXP;
   localparam int unsigned KMAX    = WIDTH - 2;
   localparam int          XW      = 2 + LS + F + 2 + WIDTH;

   logic adv, accept;
   logic s1_valid, s2_valid;
   logic s1_rmode;

   logic [LANES-1:0]        pre_sign, pre_zero, pre_inf, pre_ovf, pre_unf, pre_stk;
   logic [LANES-1:0][M-1:0] pre_ue;
   logic [LANES-1:0][F-1:0] pre_frac;
   logic [LANES-1:0][1:0]   pre_trail;

   logic [LANES-1:0]        s1_sign, s1_zero, s1_inf, s1_ovf, s1_stk;
   logic [LANES-1:0][M-1:0] s1_ue;
   logic [LANES-1:0][F-1:0] s1_frac;
   logic [LANES-1:0][1:0]   s1_trail;

   logic [LANES*WIDTH-1:0]  enc_bits, s2_bits;
   logic [CNT_W-1:0]        unf_cnt, ovf_cnt;

   // Regime is produced by an arithmetic shift of {run, ~run, tail}: the run bit
   // replicates into the regime, everything shifted past the word feeds rounding.
   function automatic logic [WIDTH-1:0] encode(
      input logic           sgn,
      input logic           zero,
      input logic           inf,
      input logic           ovf,
      input logic [M-1:0]   ue,
      input logic [F-1:0]   frac,
      input logic [1:0]     trail,
      input logic           stk
   );
      int unsigned      kk, sh;
      logic             run, rnd, sticky, up;
      logic [XW-1:0]    x, xs;
      logic [WIDTH-2:0] body;
      logic [WIDTH-1:0] mag, res;
      kk     = 32'(ue) >> LS;
      run    = (kk >= KMAX);
      sh     = run ? (kk - KMAX) : (KMAX - 1 - kk);
      x      = {run, ~run, ue[LS-1:0], frac, trail, {WIDTH{1'b0}}};
      xs     = $signed(x) >>> sh;
      body   = xs[XW-1 -: WIDTH-1];
      rnd    = xs[XW-WIDTH];
      sticky = stk | (|xs[XW-WIDTH-1:0]);
      up     = rnd & (sticky | body[0]) & ~(&body);
      mag    = {1'b0, body + (WIDTH-1)'(up)};
      if (ovf)
         mag = {1'b0, {(WIDTH-1){1'b1}}};
      res = sgn ? -mag : mag;
      if (inf)
         res = {1'b1, {(WIDTH-1){1'b0}}};
      if (zero)
         res = '0;
      return res;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] cnt,
      input logic [LANES-1:0] flags
   );
      logic [CNT_W:0] sum;
      sum = {1'b0, cnt};
      for (int unsigned i = 0; i < LANES; i++)
         sum = sum + (CNT_W+1)'(flags[i]);
      return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   endfunction

   assign adv      = !s2_valid || outReady;
   assign inReady  = adv;
   assign accept   = inValid && adv;
   assign outValid = s2_valid;
   assign outBits  = s2_bits;
   assign underflowCount = unf_cnt;
   assign overflowCount  = ovf_cnt;

   always_comb begin
      int  se;
      logic special;
      pre_sign  = inSign;
      pre_zero  = inIsZero;
      pre_inf   = inIsInf;
      pre_ovf   = '0;
      pre_unf   = '0;
      pre_stk   = '0;
      pre_ue    = '0;
      pre_frac  = '0;
      pre_trail = '0;
      se        = 0;
      special   = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         se         = int'($signed(inSignedLogExp[i*M +: M]));
         special    = inIsZero[i] | inIsInf[i];
         pre_unf[i] = !special && (se < MIN_EXP);
         pre_ovf[i] = !special && (se > MAX_EXP);
         // Saturated underflow keeps exponent/fraction/rounding at zero, which encodes minpos.
         if (pre_unf[i]) begin
            if (UNDERFLOW_SAT == 0)
               pre_zero[i] = 1'b1;
         end else if (!special && !pre_ovf[i]) begin
            pre_ue[i]    = M'(se + MAX_EXP);
            pre_frac[i]  = inLogFrac[i*F +: F];
            pre_trail[i] = inTrailingBits[i*2 +: 2];
            pre_stk[i]   = inStickyBit[i];
         end
      end
   end

   always_comb begin
      enc_bits = '0;
      for (int unsigned i = 0; i < LANES; i++)
         enc_bits[i*WIDTH +: WIDTH] = encode(s1_sign[i], s1_zero[i], s1_inf[i], s1_ovf[i],
                                             s1_ue[i], s1_frac[i],
                                             s1_trail[i] & {2{~s1_rmode}},
                                             s1_stk[i] & ~s1_rmode);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_rmode <= 1'b0;
         s1_sign  <= '0;
         s1_zero  <= '0;
         s1_inf   <= '0;
         s1_ovf   <= '0;
         s1_stk   <= '0;
         s1_ue    <= '0;
         s1_frac  <= '0;
         s1_trail <= '0;
         s2_valid <= 1'b0;
         s2_bits  <= '0;
      end else if (adv) begin
         s1_valid <= inValid;
         s1_rmode <= inRoundMode;
         s1_sign  <= pre_sign;
         s1_zero  <= pre_zero;
         s1_inf   <= pre_inf;
         s1_ovf   <= pre_ovf;
         s1_stk   <= pre_stk;
         s1_ue    <= pre_ue;
         s1_frac  <= pre_frac;
         s1_trail <= pre_trail;
         s2_valid <= s1_valid;
         s2_bits  <= enc_bits;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         unf_cnt <= '0;
         ovf_cnt <= '0;
      end else if (clearCounts) begin
         unf_cnt <= '0;
         ovf_cnt <= '0;
      end else if (accept) begin
         unf_cnt <= sat_add(unf_cnt, pre_unf);
         ovf_cnt <= sat_add(ovf_cnt, pre_ovf);
      end
   end

endmodule

// File: tb/tb_log_unpacked_to_compact_pipe.sv
// Directed bench: a flush-underflow build (CNT_W=16) and a saturate-underflow build (CNT_W=4)
// share all inputs; outputs of each are checked against hand-computed values.
module tb_log_unpacked_to_compact_pipe;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        inValid = 1'b0;
   logic [3:0]  inSign = '0, inIsZero = '0, inIsInf = '0, inStickyBit = '0;
   logic [19:0] inSignedLogExp = '0;
   logic [15:0] inLogFrac = '0;
   logic [7:0]  inTrailingBits = '0;
   logic        inRoundMode = 1'b0;
   logic        outReady = 1'b1;
   logic        clearCounts = 1'b0;

   logic        ready_a, ready_b, valid_a, valid_b;
   logic [31:0] bits_a, bits_b;
   logic [15:0] unf_a, ovf_a;
   logic [3:0]  unf_b, ovf_b;

   always #5 clock = ~clock;

   log_unpacked_to_compact_pipe #(.WIDTH(8), .LS(1), .LANES(4), .UNDERFLOW_SAT(0), .CNT_W(16)) u_a (
      .clock(clock), .resetn(resetn), .inValid(inValid), .inReady(ready_a),
      .inSign(inSign), .inIsZero(inIsZero), .inIsInf(inIsInf),
      .inSignedLogExp(inSignedLogExp), .inLogFrac(inLogFrac),
      .inTrailingBits(inTrailingBits), .inStickyBit(inStickyBit), .inRoundMode(inRoundMode),
      .outValid(valid_a), .outReady(outReady), .outBits(bits_a),
      .clearCounts(clearCounts), .underflowCount(unf_a), .overflowCount(ovf_a));

   log_unpacked_to_compact_pipe #(.WIDTH(8), .LS(1), .LANES(4), .UNDERFLOW_SAT(1), .CNT_W(4)) u_b (
      .clock(clock), .resetn(resetn), .inValid(inValid), .inReady(ready_b),
      .inSign(inSign), .inIsZero(inIsZero), .inIsInf(inIsInf),
      .inSignedLogExp(inSignedLogExp), .inLogFrac(inLogFrac),
      .inTrailingBits(inTrailingBits), .inStickyBit(inStickyBit), .inRoundMode(inRoundMode),
      .outValid(valid_b), .outReady(outReady), .outBits(bits_b),
      .clearCounts(clearCounts), .underflowCount(unf_b), .overflowCount(ovf_b));

   typedef struct {
      logic [3:0]  sgn, zro, inf;
      logic [19:0] exp;
      logic [15:0] frc;
      logic [7:0]  trl;
      logic [3:0]  stk;
      logic        rm;
      logic [31:0] ea, eb;
      int unsigned unf, ovf;
   } vec_t;

   vec_t        vt[9];
   int          n_vec = 0, n_err = 0, n_cmp = 0;
   int          sent, recv, p;
   bit          started, stalled;
   logic [31:0] held;
   bit          pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   function automatic logic [19:0] pe(input int e0, input int e1, input int e2, input int e3);
      return {5'(e3), 5'(e2), 5'(e1), 5'(e0)};
   endfunction

   function automatic vec_t mk(input logic [19:0] e);
      vec_t t;
      t = '{4'h0, 4'h0, 4'h0, e, 16'h0, 8'h0, 4'h0, 1'b0, 32'h0, 32'h0, 0, 0};
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      inSign = t.sgn; inIsZero = t.zro; inIsInf = t.inf;
      inSignedLogExp = t.exp; inLogFrac = t.frc;
      inTrailingBits = t.trl; inStickyBit = t.stk; inRoundMode = t.rm;
   endtask

   // Present one beat and hold it until accepted (bounded), leaving the bench #1 after the edge.
   task automatic push(input vec_t t);
      int waited;
      drive(t);
      inValid = 1'b1;
      waited = 0;
      while (!ready_a && waited < 10) begin
         @(posedge clock); #1;
         waited++;
      end
      if (waited == 10) chk("push_ready_timeout", ready_a, 1);
      @(posedge clock); #1;
      inValid = 1'b0;
      n_vec++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{4'h0, 4'h0, 4'h0, pe(0, 0, 0, 0), 16'h0000, 8'h00, 4'h0, 1'b0, 32'h40404040, 32'h40404040, 0, 0};
      vt[1] = '{4'h0, 4'h0, 4'h0, pe(0, 0, 0, 0), 16'h0000, 8'hAA, 4'h0, 1'b0, 32'h40404040, 32'h40404040, 0, 0};
      vt[2] = '{4'h0, 4'h0, 4'h0, pe(0, 0, 0, 0), 16'h0000, 8'hAA, 4'hF, 1'b0, 32'h41414141, 32'h41414141, 0, 0};
      vt[3] = '{4'h0, 4'h0, 4'h0, pe(0, 0, 0, 0), 16'h0000, 8'hFF, 4'h0, 1'b1, 32'h40404040, 32'h40404040, 0, 0};
      vt[4] = '{4'h0, 4'h0, 4'h0, pe(-13, 13, 0, -12), 16'h0000, 8'h00, 4'h0, 1'b0, 32'h01407F00, 32'h01407F01, 1, 1};
      vt[5] = '{4'h1, 4'h0, 4'h0, pe(-13, 13, 0, -12), 16'h0000, 8'h00, 4'h0, 1'b0, 32'h01407F00, 32'h01407FFF, 2, 2};
      vt[6] = '{4'h0, 4'h4, 4'h2, pe(0, 14, -15, 1), 16'h5000, 8'h00, 4'h0, 1'b0, 32'h55008040, 32'h55008040, 2, 2};
      vt[7] = '{4'h3, 4'h0, 4'h0, pe(0, 13, -1, 12), 16'hF000, 8'hC0, 4'h0, 1'b0, 32'h7F3081C0, 32'h7F3081C0, 2, 3};
      vt[8] = '{4'h0, 4'h0, 4'h0, pe(1, -11, 11, 12), 16'h000F, 8'h82, 4'hC, 1'b0, 32'h7F7F0260, 32'h7F7F0260, 2, 3};

      // Reset state
      #12;
      chk("rst_valid_a", valid_a, 0);
      chk("rst_ready_a", ready_a, 1);
      chk("rst_bits_a", bits_a, 0);
      chk("rst_bits_b", bits_b, 0);
      chk("rst_unf_a", unf_a, 0);
      chk("rst_ovf_a", ovf_a, 0);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;

      // Table vectors: one beat each, outReady high, two-cycle latency
      for (int v = 0; v < 9; v++) begin
         drive(vt[v]);
         inValid = 1'b1;
         chk($sformatf("v%0d_in_ready", v), ready_a, 1);
         @(posedge clock); #1;
         inValid = 1'b0;
         chk($sformatf("v%0d_early_valid", v), valid_a, 0);
         @(posedge clock); #1;
         chk($sformatf("v%0d_valid_a", v), valid_a, 1);
         chk($sformatf("v%0d_valid_b", v), valid_b, 1);
         chk($sformatf("v%0d_bits_a", v), bits_a, vt[v].ea);
         chk($sformatf("v%0d_bits_b", v), bits_b, vt[v].eb);
         chk($sformatf("v%0d_unf_a", v), unf_a, vt[v].unf);
         chk($sformatf("v%0d_ovf_a", v), ovf_a, vt[v].ovf);
         chk($sformatf("v%0d_unf_b", v), unf_b, vt[v].unf);
         chk($sformatf("v%0d_ovf_b", v), ovf_b, vt[v].ovf);
         n_vec++;
      end
      @(posedge clock); #1;
      chk("drain_valid", valid_a, 0);

      // Stream of 6 beats with downstream stalls
      sent = 0; recv = 0; p = 0; started = 0; stalled = 0; held = '0;
      for (int c = 0; c < 40 && recv < 6; c++) begin
         @(negedge clock);
         if (valid_a) started = 1;
         if (started) begin
            outReady = (p < 6) ? pat[p] : 1'b1;
            p++;
         end else begin
            outReady = 1'b1;
         end
         drive(mk(pe(0, 0, 0, 0)));
         inLogFrac = {4{4'(sent)}};
         inValid = (sent < 6);
         #1;
         if (stalled) begin
            chk("stall_hold_valid", valid_a, 1);
            chk("stall_hold_bits", bits_a, held);
         end
         if (valid_a && !outReady) begin
            chk("stall_in_ready_a", ready_a, 0);
            chk("stall_in_ready_b", ready_b, 0);
         end
         if (valid_a && outReady) begin
            chk($sformatf("stream%0d_bits_a", recv), bits_a, 32'h40404040 + 32'(recv) * 32'h01010101);
            chk($sformatf("stream%0d_bits_b", recv), bits_b, 32'h40404040 + 32'(recv) * 32'h01010101);
            recv++;
         end
         stalled = valid_a && !outReady;
         held = bits_a;
         if (inValid && ready_a) sent++;
      end
      chk("stream_delivered", 32'(recv), 6);
      @(negedge clock);
      inValid = 1'b0;
      outReady = 1'b1;
      n_vec += 6;
      @(posedge clock); #1;
      @(posedge clock); #1;

      // Counter saturation on the 4-bit build, then clear beating a same-cycle increment
      clearCounts = 1'b1;
      @(posedge clock); #1;
      clearCounts = 1'b0;
      chk("clr_unf_a", unf_a, 0);
      chk("clr_unf_b", unf_b, 0);
      chk("clr_ovf_a", ovf_a, 0);
      for (int b = 0; b < 3; b++) push(mk(pe(-14, -14, -14, -14)));
      chk("sat12_unf_a", unf_a, 12);
      chk("sat12_unf_b", unf_b, 12);
      for (int b = 0; b < 2; b++) push(mk(pe(-14, -14, -14, -14)));
      chk("sat20_unf_a", unf_a, 20);
      chk("sat_hold_unf_b", unf_b, 15);
      chk("sat_ovf_b", ovf_b, 0);
      clearCounts = 1'b1;
      push(mk(pe(-13, -13, 0, 0)));
      clearCounts = 1'b0;
      chk("clr_same_unf_a", unf_a, 0);
      chk("clr_same_unf_b", unf_b, 0);
      push(mk(pe(-13, -13, 0, 0)));
      chk("post_clr_unf_a", unf_a, 2);
      chk("post_clr_unf_b", unf_b, 2);
      @(posedge clock); #1;
      @(posedge clock); #1;

      // Asynchronous reset with two beats in flight
      drive(mk(pe(-13, 13, 0, 0)));
      inValid = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      inValid = 1'b0;
      chk("inflight_valid", valid_a, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_valid_a", valid_a, 0);
      chk("arst_valid_b", valid_b, 0);
      chk("arst_bits_a", bits_a, 0);
      chk("arst_unf_a", unf_a, 0);
      chk("arst_ovf_a", ovf_a, 0);
      chk("arst_ready_a", ready_a, 1);
      @(negedge clock);
      resetn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         chk($sformatf("post_rst%0d_valid_a", c), valid_a, 0);
         chk($sformatf("post_rst%0d_valid_b", c), valid_b, 0);
      end
      chk("post_rst_unf_b", unf_b, 0);
      chk("post_rst_ovf_b", ovf_b, 0);
      n_vec += 2;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
